output_sequencer: RTL and testbench
===================================

# output_sequencer

Sequences readout of the 16-word hash result bank to the byte-wide host transmit link. On a start request it walks word index 0..15 and drives the one-hot word-select bus that steers the result-bank mux. It captures each selected 64-bit word and serializes it MSB-byte-first over a valid/ready byte handshake, preceded by one sync byte. It sits between the hash result bank and the UART transmitter.

## Interface
- WORD_WIDTH, 64, width of one result word; must be a multiple of 8
- SYNC_BYTE, 8'hA5, frame header byte sent before word 0
- clk_i  in  1  system clock; all state changes on the rising edge
- rst_i  in  1  reset; asynchronous, active-high
- start_i  in  1  request one full frame; sampled only in IDLE
- word_data_i  in  WORD_WIDTH  result word currently selected by word_select_o (external combinational mux)
- tx_ready_i  in  1  transmitter can accept a byte this cycle
- word_select_o  out  16  one-hot select of the word being read; all-zero when not reading
- tx_data_o  out  8  byte offered to the transmitter
- tx_valid_o  out  1  tx_data_o is valid
- busy_o  out  1  a frame is in progress (any state other than IDLE)
- done_o  out  1  one-cycle pulse when a frame completes

## Operation
- States: IDLE, HDR, LOAD, SEND, DONE.
- IDLE: outputs idle. start_i=1 -> HDR, word index cleared to 0.
- HDR: tx_valid_o=1, tx_data_o=SYNC_BYTE. On valid&ready -> LOAD.
- LOAD: word_select_o = one-hot(index). Word mux settles this cycle, and word_data_i is captured into the shift register at the end of the cycle. tx_valid_o=0. -> SEND.
- SEND: tx_valid_o=1, tx_data_o = shift register bits [WORD_WIDTH-1 -: 8]. Each accept (valid&ready) shifts left 8 and increments the byte counter. After accepting byte WORD_WIDTH/8-1:
  - if index<15, increment index and go to LOAD;
  - if index=15, go to DONE.
- DONE: done_o=1 and word_select_o=0 for one cycle, then IDLE.
- word_select_o holds one-hot(index) in LOAD and SEND. It is 0 in IDLE, HDR and DONE.
- Handshake rules:
  - Once tx_valid_o rises, it and tx_data_o stay stable until accepted.
  - There is no combinational path from tx_ready_i to tx_valid_o or tx_data_o.
- start_i while busy_o=1 is ignored; it is not queued.
- Index is 4 bits, and the byte counter is log2(WORD_WIDTH/8) bits. Neither wraps inside a frame; both clear on entry to HDR.
- Reset, asserted at any time including mid-frame: the state returns to IDLE immediately. Any partial frame is abandoned and is not resumed.

## Timing
- Reset values: state IDLE; word_select_o=0; tx_data_o=8'h00; tx_valid_o=0; busy_o=0; done_o=0; index, byte counter and shift register all 0.
- start_i at cycle 0 gives:
  - HDR at cycle 1, with tx_valid_o=1 and busy_o=1;
  - with tx_ready_i held high, LOAD word 0 at cycle 2 and the first data byte valid at cycle 3.
- With tx_ready_i continuously high, each word costs 1 LOAD cycle plus 8 SEND cycles.
  - The full frame is 1 + 16×9 = 145 cycles from HDR entry to DONE entry.
  - done_o goes high at cycle 146 and busy_o drops at cycle 147.
- tx_ready_i low stalls SEND/HDR indefinitely with the byte held. The stall has no effect in LOAD.
- A new frame can start on the first IDLE cycle after DONE.

## Structure
- Shared package: NUM_WORDS=16, WORD_IDX_W=4, state enum encoding.
- One sub-module: the existing 4-to-16 one-hot decoder output_logic, instantiated to produce word_select_o from the index. It is gated to zero outside LOAD/SEND and registered so the output stays glitch-free.
- The shift register, counters and FSM stay in this module.

## Test plan
- Reset defaults: assert rst_i mid-cycle with no clock edge -> all outputs read 0 immediately.
- Full frame, ready always 1, word w = 64'h0101010101010101×(w+1):
  - bytes are A5, then 01×8, 02×8, …, 10×8 (129 bytes);
  - done_o pulses at cycle 146;
  - word_select_o steps 0x0001..0x8000.
- Backpressure: tx_ready_i toggles 1/0 randomly -> identical byte stream, and tx_data_o is stable during every stall.
- Byte order: word 0 = 64'h0011223344556677 -> bytes 00,11,22,…,77 in that order.
- start_i pulsed during word 5 -> ignored, and the frame finishes normally with exactly one done_o.
- rst_i asserted while sending byte 3 of word 7 -> IDLE and word_select_o=0 next; a subsequent start_i produces a complete fresh frame beginning with A5.

Source files
------------

// File: rtl/output_sequencer_pkg.sv
// Shared definitions for the output sequencer.
// Contents:
//   NUM_WORDS / WORD_IDX_W - result bank geometry
//   ST_*                   - FSM state encoding
//   onehot_sel()           - 4-to-16 one-hot decode helper
package output_sequencer_pkg;

  localparam int NUM_WORDS  = 16;
  localparam int WORD_IDX_W = 4;
  localparam int STATE_W    = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_HDR  = 3'd1;
  localparam logic [STATE_W-1:0] ST_LOAD = 3'd2;
  localparam logic [STATE_W-1:0] ST_SEND = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

  function automatic logic [NUM_WORDS-1:0] onehot_sel(input logic [WORD_IDX_W-1:0] idx);
    onehot_sel      = '0;
    onehot_sel[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/output_logic.sv
// Registered 4-to-16 one-hot decoder driving the result-bank mux select.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   en       - when low the select is forced to all-zero
//   idx      - word index to decode
//   sel      - registered one-hot select (glitch-free, no decode hazards)
module output_logic
  import output_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [WORD_IDX_W-1:0] idx,
  output logic [NUM_WORDS-1:0]  sel
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel <= '0;
    end else if (en) begin
      sel <= onehot_sel(idx);
    end else begin
      sel <= '0;
    end
  end

endmodule

// File: rtl/output_sequencer.sv
// Reads the 16-word hash result bank out to a byte-wide transmit link.
// Frame: one SYNC_BYTE, then words 0..15, each sent MSB byte first.
// Ports:
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   start_i        - request one frame (only looked at while idle)
//   word_data_i    - word chosen by word_select_o via an external mux
//   tx_ready_i     - transmitter accepts the offered byte this cycle
//   word_select_o  - one-hot word select, zero when not reading
//   tx_data_o      - offered byte
//   tx_valid_o     - offered byte is valid
//   busy_o         - frame in progress
//   done_o         - single-cycle pulse at frame end
// Handshake: a byte moves on any rising edge where tx_valid_o and
// tx_ready_i are both high. Once tx_valid_o is raised, it and tx_data_o
// hold until that transfer. Both are decoded from registers only, so
// tx_ready_i never reaches them combinationally.
module output_sequencer
  import output_sequencer_pkg::*;
#(
  parameter int         WORD_WIDTH = 64,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [WORD_WIDTH-1:0] word_data_i,
  input  logic                  tx_ready_i,
  output logic [NUM_WORDS-1:0]  word_select_o,
  output logic [7:0]            tx_data_o,
  output logic                  tx_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BYTES = WORD_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [WORD_IDX_W-1:0] LAST_IDX  = WORD_IDX_W'(NUM_WORDS - 1);

  // state is the FSM debug point for external checkers
  logic [STATE_W-1:0]    state, state_d;
  logic [WORD_IDX_W-1:0] idx, idx_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [WORD_WIDTH-1:0] shreg, shreg_d;
  logic                  sel_en;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    shreg_d = shreg;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_HDR;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_HDR: begin
        if (tx_ready_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // select has been stable all cycle, so the mux output is settled
        shreg_d = word_data_i;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready_i) begin
          shreg_d = shreg << 8;
          if (cnt == LAST_BYTE) begin
            cnt_d = '0;
            if (idx == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx + 1'b1;
              state_d = ST_LOAD;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      idx   <= '0;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      shreg <= shreg_d;
    end
  end

  // The decoder registers from next-state values so that its output is
  // aligned with the LOAD/SEND cycles rather than one cycle late.
  assign sel_en = (state_d == ST_LOAD) || (state_d == ST_SEND);

  output_logic u_output_logic (
    .clk (clk_i),
    .rst (rst_i),
    .en  (sel_en),
    .idx (idx_d),
    .sel (word_select_o)
  );

  assign tx_valid_o = (state == ST_HDR) || (state == ST_SEND);
  assign tx_data_o  = (state == ST_HDR)  ? SYNC_BYTE :
                      (state == ST_SEND) ? shreg[WORD_WIDTH-1 -: 8] : 8'h00;
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = (state == ST_DONE);

endmodule

// File: tb/tb_output_sequencer.sv
module tb_output_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] word_data;
  logic        tx_ready;
  logic [15:0] sel;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [63:0] bank [16];
  logic [7:0]  exp_q [$];

  // monitor state
  bit          mon_en = 0;
  int          acc_cnt, done_cnt, done_cyc, sel_idx;
  logic [15:0] last_sel;
  logic        prev_valid, prev_ready;
  logic [7:0]  prev_data;

  output_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .word_data_i   (word_data),
    .tx_ready_i    (tx_ready),
    .word_select_o (sel),
    .tx_data_o     (tx_data),
    .tx_valid_o    (tx_valid),
    .busy_o        (busy),
    .done_o        (done)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // external result-bank mux
  always_comb begin
    word_data = '0;
    for (int i = 0; i < 16; i++) if (sel[i]) word_data = bank[i];
  end

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference stream: sync byte, then each word MSB byte first
  task automatic build_expect();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int w = 0; w < 16; w++)
      for (int b = 7; b >= 0; b--) exp_q.push_back(bank[w][b*8 +: 8]);
  endtask

  task automatic mon_clear();
    acc_cnt = 0; done_cnt = 0; done_cyc = 0; sel_idx = 0;
    last_sel = '0; prev_valid = 0; prev_ready = 0; prev_data = '0;
  endtask

  // scoreboard monitor, samples mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      logic [7:0]  e;
      logic [15:0] one;
      if (prev_valid && !prev_ready) begin
        chk(tx_valid == 1'b1, "stall_valid", tx_valid, 1);
        chk(tx_data == prev_data, "stall_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk(0, "extra_byte", tx_data, 0);
        end else begin
          e = exp_q.pop_front();
          chk(tx_data == e, "byte", tx_data, e);
        end
        acc_cnt++;
      end
      if (sel != '0) begin
        chk($onehot(sel), "sel_onehot", sel, 0);
        if (sel != last_sel) begin
          one = 16'd1 << sel_idx;
          chk(sel == one, "sel_step", sel, one);
          sel_idx++;
          last_sel = sel;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk(sel == '0, "sel_in_done", sel, 0);
      end
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
    end
  end

  // one full frame; exp_at < 0 skips exact cycle checks
  task automatic run_frame(input bit rnd_ready, input bit poke, input int exp_at, input string tag);
    int  start_cyc;
    int  n;
    bit  fin;
    build_expect();
    mon_clear();
    mon_en = 1;
    @(posedge clk); #1;
    start     = 1'b1;
    tx_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    start_cyc = cyc;
    n = 0; fin = 0;
    while (!fin && n < 3000) begin
      @(posedge clk); #1;
      n++;
      start    = (poke && sel == 16'h0020) ? 1'b1 : 1'b0;
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == start_cyc + 1) begin
        chk(busy == 1'b1, {tag, "_hdr_busy"}, busy, 1);
        chk(tx_valid == 1'b1 && tx_data == 8'hA5, {tag, "_hdr_byte"}, tx_data, 8'hA5);
      end
      if (exp_at >= 0 && cyc == start_cyc + exp_at + 1)
        chk(busy == 1'b0, {tag, "_busy_drop"}, busy, 0);
      if (done_cnt > 0 && cyc >= done_cyc + 3) fin = 1;
    end
    chk(fin, {tag, "_timeout"}, n, 0);
    chk(exp_q.size() == 0, {tag, "_bytes_left"}, exp_q.size(), 0);
    chk(done_cnt == 1, {tag, "_done_count"}, done_cnt, 1);
    chk(sel_idx == 16, {tag, "_sel_words"}, sel_idx, 16);
    chk(busy == 1'b0, {tag, "_idle_after"}, busy, 0);
    if (exp_at >= 0)
      chk(done_cyc - start_cyc == exp_at, {tag, "_done_cycle"}, done_cyc - start_cyc, exp_at);
    mon_en = 0;
    start  = 1'b0;
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_busy;
    logic [15:0] exp_sel;
  } vec_t;

  vec_t tv [16];

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) bank[i] = '0;

    // reset values, no clock edge yet
    #1;
    chk(tx_valid == 0 && busy == 0 && done == 0, "reset_ctrl", {tx_valid, busy, done}, 0);
    chk(tx_data == 8'h00, "reset_data", tx_data, 0);
    chk(sel == 16'h0, "reset_sel", sel, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // byte order and stalls, cycle by cycle
    bank[0] = 64'h0011223344556677;
    bank[1] = 64'hFFEEDDCCBBAA9988;
    tv[0]  = '{1, 1, 0, 8'h00, 0, 16'h0000};
    tv[1]  = '{0, 0, 1, 8'hA5, 1, 16'h0000};
    tv[2]  = '{0, 1, 1, 8'hA5, 1, 16'h0000};
    tv[3]  = '{0, 0, 0, 8'h00, 1, 16'h0001};
    tv[4]  = '{0, 1, 1, 8'h00, 1, 16'h0001};
    tv[5]  = '{0, 0, 1, 8'h11, 1, 16'h0001};
    tv[6]  = '{0, 0, 1, 8'h11, 1, 16'h0001};
    tv[7]  = '{0, 1, 1, 8'h11, 1, 16'h0001};
    tv[8]  = '{0, 1, 1, 8'h22, 1, 16'h0001};
    tv[9]  = '{0, 0, 1, 8'h33, 1, 16'h0001};
    tv[10] = '{0, 1, 1, 8'h33, 1, 16'h0001};
    tv[11] = '{0, 1, 1, 8'h44, 1, 16'h0001};
    tv[12] = '{1, 1, 1, 8'h55, 1, 16'h0001};
    tv[13] = '{0, 1, 1, 8'h66, 1, 16'h0001};
    tv[14] = '{0, 1, 1, 8'h77, 1, 16'h0001};
    tv[15] = '{0, 0, 0, 8'h00, 1, 16'h0002};
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      start    = tv[i].start;
      tx_ready = tv[i].ready;
      chk(tx_valid == tv[i].exp_valid, $sformatf("tv%0d_valid", i), tx_valid, tv[i].exp_valid);
      if (tv[i].exp_valid)
        chk(tx_data == tv[i].exp_data, $sformatf("tv%0d_data", i), tx_data, tv[i].exp_data);
      chk(busy == tv[i].exp_busy, $sformatf("tv%0d_busy", i), busy, tv[i].exp_busy);
      chk(sel == tv[i].exp_sel, $sformatf("tv%0d_sel", i), sel, tv[i].exp_sel);
      chk(done == 1'b0, $sformatf("tv%0d_done", i), done, 0);
    end
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // pattern frame, ready held high
    for (int w = 0; w < 16; w++) bank[w] = 64'h0101010101010101 * 64'(w + 1);
    run_frame(0, 0, 146, "pattern");

    // random data, random backpressure
    for (int w = 0; w < 16; w++) bank[w] = {$urandom, $urandom};
    run_frame(1, 0, -1, "backpressure");

    // start pulses during word 5 are ignored
    for (int w = 0; w < 16; w++) bank[w] = {$urandom, $urandom};
    run_frame(0, 1, 146, "start_busy");

    // reset while byte 3 of word 7 is on offer
    for (int w = 0; w < 16; w++) bank[w] = {$urandom, $urandom};
    build_expect();
    mon_clear();
    mon_en = 1;
    @(posedge clk); #1;
    start = 1'b1; tx_ready = 1'b1;
    n = 0;
    while (!(acc_cnt == 60 && tx_valid) && n < 1000) begin
      @(posedge clk); #1;
      n++;
      start    = 1'b0;
      tx_ready = 1'($urandom_range(0, 1));
    end
    chk(n < 1000, "midreset_reach", n, 0);
    chk(sel == 16'h0080, "midreset_word7", sel, 16'h0080);
    mon_en = 0;
    #1 rst = 1'b1;
    #1;
    chk(tx_valid == 0 && busy == 0 && done == 0, "midreset_ctrl", {tx_valid, busy, done}, 0);
    chk(sel == 16'h0, "midreset_sel", sel, 0);
    chk(tx_data == 8'h00, "midreset_data", tx_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk(busy == 0 && sel == 16'h0, "after_reset_idle", {busy, sel}, 0);
    run_frame(1, 0, -1, "fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
